// File: rtl/rob_inorder_buffer.sv
// In-order-allocate, out-of-order-complete, in-order-retire reorder buffer.
// Full/empty are tracked by an occupancy counter so head==tail is never ambiguous.
module rob_inorder_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_i,
  output logic              alloc_gnt_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wr_vld_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [TAG_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_wr_o
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  alloc_q, alloc_d, vld_q, vld_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              err_q;
  logic              full, gnt, wr_ok, retire;

  assign full        = (count_q == DEPTH_C);
  // A full buffer refuses allocation even if the head retires this cycle.
  assign gnt         = alloc_req_i & ~full;
  assign wr_ok       = wr_vld_i & alloc_q[wr_tag_i] & ~vld_q[wr_tag_i];
  assign out_valid_o = alloc_q[head_q] & vld_q[head_q];
  assign retire      = out_valid_o & out_ready_i;

  assign alloc_gnt_o = gnt;
  assign alloc_tag_o = tail_q;
  assign out_data_o  = data_q[head_q];
  assign out_tag_o   = head_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = (count_q == '0);
  assign err_wr_o    = err_q;

  always_comb begin
    alloc_d = alloc_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_ok) vld_d[wr_tag_i] = 1'b1;
    if (retire) begin
      alloc_d[head_q] = 1'b0;
      vld_d[head_q]   = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // Grant slot never equals the retiring head: that needs count==DEPTH, where gnt is 0.
    if (gnt) begin
      alloc_d[tail_q] = 1'b1;
      vld_d[tail_q]   = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    case ({gnt, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      vld_q   <= vld_d;
      err_q   <= wr_vld_i & ~wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) data_q[wr_tag_i] <= wr_data_i;
  end

endmodule

// File: tb/tb_rob_inorder_buffer.sv
// Directed bench for rob_inorder_buffer: expected retirements are queued at
// allocation time and popped by a negedge monitor on every output handshake.
module tb_rob_inorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req_i = 1'b0;
  logic       alloc_gnt_o;
  logic [3:0] alloc_tag_o;
  logic       wr_vld_i = 1'b0;
  logic [3:0] wr_tag_i = '0;
  logic [7:0] wr_data_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_data_o;
  logic [3:0] out_tag_o;
  logic [4:0] count_o;
  logic       full_o, empty_o, err_wr_o;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [3:0] exp_tail = '0;

  always #5 clk = ~clk;

  rob_inorder_buffer #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_tag_o(alloc_tag_o),
    .wr_vld_i(wr_vld_i), .wr_tag_i(wr_tag_i), .wr_data_i(wr_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_tag_o(out_tag_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_wr_o(err_wr_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant is checked combinationally, then the cycle is committed.
  task automatic do_alloc(input logic [7:0] d);
    alloc_req_i = 1'b1;
    #3;
    chk("alloc_gnt", int'(alloc_gnt_o), 1);
    chk("alloc_tag", int'(alloc_tag_o), int'(exp_tail));
    sb.push_back({exp_tail, d});
    cyc();
    alloc_req_i = 1'b0;
    exp_tail = exp_tail + 4'd1;
  endtask

  task automatic do_write(input logic [3:0] t, input logic [7:0] d);
    wr_vld_i  = 1'b1;
    wr_tag_i  = t;
    wr_data_i = d;
    cyc();
    wr_vld_i  = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    #3;
    while (count_o != 5'd0 && n < 60) begin
      cyc();
      #3;
      n++;
    end
    chk("drain count", int'(count_o), 0);
    chk("drain empty", int'(empty_o), 1);
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_tail = '0;
    cyc();
    alloc_req_i = 1'b1;
    #3;
    chk("rst gnt=req", int'(alloc_gnt_o), 1);
    chk("rst count", int'(count_o), 0);
    chk("rst empty", int'(empty_o), 1);
    chk("rst full", int'(full_o), 0);
    chk("rst out_valid", int'(out_valid_o), 0);
    chk("rst out_tag", int'(out_tag_o), 0);
    chk("rst err", int'(err_wr_o), 0);
    alloc_req_i = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid_o && out_ready_i) begin
          if (sb.size() == 0) chk("unexpected retire", 1, 0);
          else begin
            e = sb.pop_front();
            chk("retire tag", int'(out_tag_o), int'(e.tag));
            chk("retire data", int'(out_data_o), int'(e.data));
          end
        end
      end
    join_none

    do_reset();

    // Out-of-order completion, in-order drain
    out_ready_i = 1'b1;
    do_alloc(8'h11);
    do_alloc(8'h22);
    do_alloc(8'h33);
    #3;
    chk("count after 3 allocs", int'(count_o), 3);
    cyc();
    do_write(4'd2, 8'h33);
    do_write(4'd0, 8'h11);
    do_write(4'd1, 8'h22);
    wait_empty();

    // Fill to 16, refused 17th, full + retire same cycle, wrap to tag 0
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) do_alloc(8'h40 + 8'(i));
    #3;
    chk("full_o", int'(full_o), 1);
    chk("count full", int'(count_o), 16);
    alloc_req_i = 1'b1;
    #1;
    chk("17th gnt", int'(alloc_gnt_o), 0);
    cyc();
    alloc_req_i = 1'b0;
    #3;
    chk("count after refused", int'(count_o), 16);
    do_write(4'd0, 8'h40);
    out_ready_i = 1'b1;
    alloc_req_i = 1'b1;
    #3;
    chk("full+retire gnt", int'(alloc_gnt_o), 0);
    chk("full+retire valid", int'(out_valid_o), 1);
    cyc();
    #3;
    chk("count after retire", int'(count_o), 15);
    do_alloc(8'h50);
    #3;
    chk("count refilled", int'(count_o), 16);
    for (int i = 1; i < 16; i++) do_write(4'(i), 8'h40 + 8'(i));
    do_write(4'd0, 8'h50);
    wait_empty();

    // Illegal writes: unallocated tag, double completion, alloc+write same slot
    do_write(4'd5, 8'h99);
    #3;
    chk("err unalloc", int'(err_wr_o), 1);
    chk("valid after bad wr", int'(out_valid_o), 0);
    cyc();
    #3;
    chk("err one-shot", int'(err_wr_o), 0);
    do_alloc(8'h61);
    do_alloc(8'h62);
    do_alloc(8'h63);
    do_alloc(8'h64);
    do_alloc(8'hA5);
    do_write(4'd5, 8'hA5);
    #3;
    chk("err first wr", int'(err_wr_o), 0);
    do_write(4'd5, 8'h5A);
    #3;
    chk("err second wr", int'(err_wr_o), 1);
    wr_vld_i = 1'b1;
    wr_tag_i = 4'd6;
    wr_data_i = 8'hEE;
    do_alloc(8'h66);
    wr_vld_i = 1'b0;
    #3;
    chk("err alloc+wr same slot", int'(err_wr_o), 1);
    do_write(4'd1, 8'h61);
    do_write(4'd2, 8'h62);
    do_write(4'd3, 8'h63);
    do_write(4'd4, 8'h64);
    do_write(4'd6, 8'h66);
    wait_empty();

    // Back-pressure: head held stable, then write-to-retiring-head flagged
    out_ready_i = 1'b0;
    do_alloc(8'h77);
    do_write(4'd7, 8'h77);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("stall valid", int'(out_valid_o), 1);
      chk("stall data", int'(out_data_o), 8'h77);
      chk("stall tag", int'(out_tag_o), 7);
      cyc();
    end
    out_ready_i = 1'b1;
    do_write(4'd7, 8'h12);
    #3;
    chk("err wr retiring head", int'(err_wr_o), 1);
    chk("count after stall", int'(count_o), 0);
    chk("valid after stall", int'(out_valid_o), 0);
    cyc();

    // Reset mid-operation with outstanding entries and a pending write
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) do_alloc(8'h80 + 8'(i));
    #3;
    chk("count before rst", int'(count_o), 5);
    cyc();
    wr_vld_i = 1'b1;
    wr_tag_i = 4'd8;
    wr_data_i = 8'hCC;
    rst = 1'b1;
    sb.delete();
    cyc();
    rst = 1'b0;
    wr_vld_i = 1'b0;
    exp_tail = '0;
    #3;
    chk("mid-rst count", int'(count_o), 0);
    chk("mid-rst empty", int'(empty_o), 1);
    chk("mid-rst valid", int'(out_valid_o), 0);
    chk("mid-rst err", int'(err_wr_o), 0);
    do_alloc(8'h5A);
    do_write(4'd0, 8'h5A);
    out_ready_i = 1'b1;
    wait_empty();

    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
